// File: rtl/univ_reg_pkg.sv
// Shared types for the universal register bank: operation codes applied to one channel.
package univ_reg_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'b000,
    LOAD = 3'b001,
    SHL  = 3'b010,
    SHR  = 3'b011,
    ROL  = 3'b100,
    ROR  = 3'b101,
    INC  = 3'b110,
    DEC  = 3'b111
  } mode_t;

endpackage

// File: rtl/univ_reg_slice.sv
// One WIDTH-bit channel of the register bank. carry_out is the carry the selected
// operation would produce this cycle; the top level captures it on acceptance.
module univ_reg_slice
  import univ_reg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             op_en,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] data,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic             carry_out
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] next_s;

  // Next value and carry for the requested operation on the current contents.
  always_comb begin
    next_s    = q_r;
    carry_out = 1'b0;
    case (mode)
      HOLD: begin
        next_s    = q_r;
        carry_out = 1'b0;
      end
      LOAD: begin
        next_s    = data;
        carry_out = 1'b0;
      end
      SHL: begin
        next_s    = {q_r[WIDTH-2:0], serial_in};
        carry_out = q_r[WIDTH-1];
      end
      SHR: begin
        next_s    = {serial_in, q_r[WIDTH-1:1]};
        carry_out = q_r[0];
      end
      ROL: begin
        next_s    = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        carry_out = q_r[WIDTH-1];
      end
      ROR: begin
        next_s    = {q_r[0], q_r[WIDTH-1:1]};
        carry_out = q_r[0];
      end
      INC: begin
        {carry_out, next_s} = {1'b0, q_r} + {{WIDTH{1'b0}}, 1'b1};
      end
      DEC: begin
        next_s    = q_r - {{(WIDTH-1){1'b0}}, 1'b1};
        carry_out = (q_r == {WIDTH{1'b0}});
      end
      default: begin
        next_s    = q_r;
        carry_out = 1'b0;
      end
    endcase
  end

  // Channel storage: clear has priority over an accepted operation.
  always_ff @(posedge Clock) begin
    if (clear) begin
      q_r <= {WIDTH{1'b0}};
    end else if (op_en) begin
      q_r <= next_s;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/univ_reg_bank.sv
// Multi-channel universal register bank: per-channel load/shift/rotate/inc/dec with
// a shared carry flag and one-cycle Done/Err pulses. Enable low clears everything.
module univ_reg_bank
  import univ_reg_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Enable,
  input  logic                         Strobe,
  input  logic [$clog2(CHANNELS)-1:0]  Sel,
  input  logic [2:0]                   Mode,
  input  logic [WIDTH-1:0]             Data,
  input  logic                         SerialIn,
  output logic [CHANNELS*WIDTH-1:0]    Q,
  output logic                         Carry,
  output logic                         Done,
  output logic                         Err
);

  localparam int SEL_W = $clog2(CHANNELS);
  localparam logic [SEL_W:0] NCH = (SEL_W + 1)'(CHANNELS);

  logic                clear_s;
  logic                sel_ok_s;
  logic [CHANNELS-1:0] op_en_s;
  logic [CHANNELS-1:0] carry_s;
  logic                carry_sel_s;
  logic                carry_r;
  logic                done_r;
  logic                err_r;

  assign clear_s  = Reset | ~Enable;
  // Only reachable as false when CHANNELS is not a power of two.
  assign sel_ok_s = ({1'b0, Sel} < NCH);

  // Channel decode and carry selection for the addressed channel.
  always_comb begin
    op_en_s     = {CHANNELS{1'b0}};
    carry_sel_s = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (Sel == SEL_W'(i)) begin
        op_en_s[i]  = Strobe;
        carry_sel_s = carry_s[i];
      end else begin
        op_en_s[i]  = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    univ_reg_slice #(.WIDTH(WIDTH)) u_slice (
      .Clock     (Clock),
      .clear     (clear_s),
      .op_en     (op_en_s[g]),
      .mode      (mode_t'(Mode)),
      .data      (Data),
      .serial_in (SerialIn),
      .q         (Q[g*WIDTH +: WIDTH]),
      .carry_out (carry_s[g])
    );
  end

  // Status flags: Carry holds unless an op is accepted or state is cleared.
  always_ff @(posedge Clock) begin
    if (clear_s) begin
      carry_r <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else if (Strobe && sel_ok_s) begin
      carry_r <= carry_sel_s;
      done_r  <= 1'b1;
      err_r   <= 1'b0;
    end else if (Strobe) begin
      carry_r <= carry_r;
      done_r  <= 1'b0;
      err_r   <= 1'b1;
    end else begin
      carry_r <= carry_r;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end
  end

  assign Carry = carry_r;
  assign Done  = done_r;
  assign Err   = err_r;

endmodule

// File: doc/univ_reg_bank.md
# univ_reg_bank

Parametrised bank of CHANNELS independent WIDTH-bit edge-triggered registers, each individually addressable for load, shift, rotate, increment and decrement operations. It replaces the fixed 4-bit enable/reset data-holding latch with a fully synchronous, multi-channel, multi-mode register, and keeps the existing enable-clears-contents semantics. It sits between the datapath control logic and the display/ALU operand paths.

## Interface
- WIDTH, default 4: bits per channel, ≥ 2
- CHANNELS, default 4: number of channels, ≥ 2
- Clock  in  1  rising-edge clock
- Reset  in  1  reset; synchronous, active-high
- Enable  in  1  global enable; low clears all state on the next edge
- Strobe  in  1  operation request, sampled each rising edge
- Sel  in  $clog2(CHANNELS)  target channel
- Mode  in  3  operation code (see Operation)
- Data  in  WIDTH  parallel load value
- SerialIn  in  1  fill bit for SHL/SHR
- Q  out  CHANNELS*WIDTH  all channel contents; channel i at bits [i*WIDTH +: WIDTH]
- Carry  out  1  bit shifted/rotated/carried out by the last accepted op
- Done  out  1  one-cycle pulse: op accepted on the previous edge
- Err  out  1  one-cycle pulse: Strobe with Sel ≥ CHANNELS

## Operation
- Priority per edge: Reset > !Enable > Strobe > hold.
- Reset or !Enable: Q = 0 (all channels), Carry = 0, Done = 0, Err = 0.
- Strobe=1, Sel < CHANNELS: channel Sel updated per Mode; other channels hold; Done = 1 next cycle.
- Strobe=1, Sel ≥ CHANNELS (non-power-of-2 CHANNELS only): no channel changes, Carry holds, Err = 1, Done = 0.
- Strobe=0: everything holds; Done/Err = 0.
- Mode codes (R = current value of channel Sel):
  - 000 HOLD: R unchanged, Carry = 0, Done still pulses.
  - 001 LOAD: R = Data, Carry = 0.
  - 010 SHL: R = {R[W-2:0], SerialIn}, Carry = R[W-1].
  - 011 SHR: R = {SerialIn, R[W-1:1]}, Carry = R[0].
  - 100 ROL: R = {R[W-2:0], R[W-1]}, Carry = R[W-1].
  - 101 ROR: R = {R[0], R[W-1:1]}, Carry = R[0].
  - 110 INC: R = R+1 mod 2^W, Carry = 1 iff R was all-ones.
  - 111 DEC: R = R−1 mod 2^W, Carry = 1 iff R was zero (borrow).
- Carry changes only on accepted strobes, reset or !Enable; otherwise it holds.
- Arithmetic is unsigned, WIDTH bits, wraps silently; carry is the only overflow indication.

## Timing
- All outputs registered; no combinational input-to-output path.
- Latency: Strobe at edge N → Q, Carry, Done valid after edge N; Done/Err high for exactly one cycle.
- Back-to-back strobes are accepted every cycle. A second op on the same channel uses the result of the first.
- Reset asserted mid-sequence: the in-flight op is discarded and all outputs are 0 after that edge. The first op is accepted on the first edge with Reset=0, Enable=1.
- Enable deasserted with Strobe=1: the clear wins and Done stays 0.
- Reset values: Q = 0, Carry = 0, Done = 0, Err = 0.

## Structure
- Package univ_reg_pkg: enum mode_t (HOLD, LOAD, SHL, SHR, ROL, ROR, INC, DEC) with the 3-bit encodings above.
- Sub-module univ_reg_slice: one WIDTH-bit channel with inputs op_en, mode, data, serial_in and outputs q, carry_out. Instantiated CHANNELS times by a generate loop.
- Top level owns Sel decode, Sel range check, the Carry mux and the Done/Err registers.

## Test plan
- Reset, then LOAD ch2 with 4'hA → Q[11:8]=4'hA, other channels 0, Done pulse one cycle, Carry=0.
- ch1=4'b1001: SHL SerialIn=0 → 4'b0010, Carry=1; then ROR → 4'b0001, Carry=0; then SHR SerialIn=1 → 4'b1000, Carry=1.
- ch0=4'hF: INC → 4'h0, Carry=1; DEC → 4'hF, Carry=1; DEC → 4'hE, Carry=0.
- Consecutive strobes on ch3 (LOAD 4'h5, INC, INC) on three edges → 5, 6, 7. Done high for three cycles.
- Enable=0 with Strobe=1 LOAD → all Q=0, Carry=0, Done=0. Reset asserted mid-INC sequence → all zero, and the sequence resumes from 0 after release.
- CHANNELS=3: Strobe with Sel=3 → no Q change, Err pulse, Done=0. Then Sel=2 LOAD 4'h3 → accepted normally.
